// File: rtl/led_seq_pkg.sv
// Shared types and next-pattern logic for the LED pattern sequencer.
// Patterns are handled at MAX_LEDS width; callers zero-extend and truncate.
package led_seq_pkg;

    localparam int unsigned MAX_LEDS = 64;

    typedef logic [MAX_LEDS-1:0] led_vec_t;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_SWAP   = 2'd3
    } mode_t;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_PAUSE = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic is_onehot(input led_vec_t p);
        return (p != '0) && ((p & (p - led_vec_t'(1))) == '0);
    endfunction

    function automatic logic msb_set(input led_vec_t p, input int unsigned n);
        return (p & (led_vec_t'(1) << (n - 1))) != '0;
    endfunction

    // Next pattern for an n-wide pattern; bits at and above n are zero on return.
    function automatic led_vec_t next_pattern(input led_vec_t p, input int unsigned n,
                                              input mode_t mode, input logic dir,
                                              input logic entering);
        led_vec_t mask;
        led_vec_t pairs;
        led_vec_t q;
        mask  = (led_vec_t'(1) << n) - led_vec_t'(1);
        pairs = {(MAX_LEDS/2){2'b01}};
        q     = p;
        case (mode)
            MODE_ROTL: q = (p << 1) | (p >> (n - 1));
            MODE_ROTR: q = (p >> 1) | (p << (n - 1));
            MODE_SWAP: q = ((p & pairs) << 1) | ((p >> 1) & pairs);
            MODE_BOUNCE: begin
                if (entering || !is_onehot(p)) begin
                    q = led_vec_t'(1);
                end else if (dir == DIR_UP) begin
                    q = msb_set(p, n) ? (p >> 1) : (p << 1);
                end else begin
                    q = p[0] ? (p << 1) : (p >> 1);
                end
            end
            default: q = p;
        endcase
        return q & mask;
    endfunction

    function automatic logic next_dir(input led_vec_t p, input int unsigned n,
                                      input mode_t mode, input logic dir,
                                      input logic entering);
        logic d;
        d = dir;
        if (mode == MODE_BOUNCE) begin
            if (entering || !is_onehot(p)) begin
                d = DIR_UP;
            end else if ((dir == DIR_UP) && msb_set(p, n)) begin
                d = DIR_DOWN;
            end else if ((dir == DIR_DOWN) && p[0]) begin
                d = DIR_UP;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/led_step_div.sv
// Free-running step divider: counts 0..STEP_DIV-1 while enabled, wrap_c marks the last count.
module led_step_div #(
    parameter int unsigned STEP_DIV = 6000000,
    parameter int unsigned DIV_W    = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap_c
);

    logic [DIV_W-1:0] cnt;

    assign wrap_c = en && (cnt == DIV_W'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: divider-timed steps advance the pattern in one of four modes.
// Define LED_SEQ_PWM_EN to add the brightness input and PWM gating of the LED outputs.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned         NUM_LEDS     = 4,
    parameter int unsigned         STEP_DIV     = 6000000,
    parameter int unsigned         DIV_W        = 24,
    parameter logic [NUM_LEDS-1:0] INIT_PATTERN = {(NUM_LEDS/2){2'b10}}
`ifdef LED_SEQ_PWM_EN
    ,
    parameter int unsigned         PWM_BITS     = 4
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [NUM_LEDS-1:0] pattern_in,
`ifdef LED_SEQ_PWM_EN
    input  logic [PWM_BITS-1:0] brightness,
`endif
    output logic [NUM_LEDS-1:0] leds,
    output logic                led_aux,
    output logic                step
);

    logic [0:0]          state, state_next;
    logic                run_c;
    logic                step_c;
    logic [NUM_LEDS-1:0] pattern, pattern_d;
    logic                dir, dir_d;
    mode_t               last_mode, last_mode_d;
    mode_t               mode_c;
    logic                entering_c;

    led_step_div #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_c),
        .clr    (load),
        .wrap_c (step_c)
    );

    // Run/pause control
    always_comb begin
        state_next = state;
        run_c      = 1'b0;
        case (state)
            ST_RUN: begin
                run_c = enable;
                if (!enable) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                run_c = enable;
                if (enable) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign mode_c     = mode_t'(mode);
    assign entering_c = (mode_c == MODE_BOUNCE) && (last_mode != MODE_BOUNCE);

    // Load wins over a coincident step
    always_comb begin
        pattern_d   = pattern;
        dir_d       = dir;
        last_mode_d = last_mode;
        if (load) begin
            pattern_d = pattern_in;
        end else if (step_c) begin
            pattern_d   = NUM_LEDS'(next_pattern(led_vec_t'(pattern), NUM_LEDS, mode_c,
                                                 dir, entering_c));
            dir_d       = next_dir(led_vec_t'(pattern), NUM_LEDS, mode_c, dir, entering_c);
            last_mode_d = mode_c;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            pattern   <= INIT_PATTERN;
            dir       <= DIR_UP;
            last_mode <= MODE_ROTL;
            leds      <= INIT_PATTERN;
            step      <= 1'b0;
            led_aux   <= 1'b1;
        end else begin
            state     <= state_next;
            pattern   <= pattern_d;
            dir       <= dir_d;
            last_mode <= last_mode_d;
            step      <= step_c && !load;
            led_aux   <= 1'b1;
`ifdef LED_SEQ_PWM_EN
            leds      <= pattern_d & {NUM_LEDS{pwm_cnt < brightness}};
`else
            leds      <= pattern_d;
`endif
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with NUM_LEDS=4, STEP_DIV=4.
module tb_led_pattern_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic [3:0] pattern_in;
`ifdef LED_SEQ_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif
    logic [3:0] leds;
    logic       led_aux;
    logic       step;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .NUM_LEDS (4),
        .STEP_DIV (4),
        .DIV_W    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .load       (load),
        .pattern_in (pattern_in),
`ifdef LED_SEQ_PWM_EN
        .brightness (brightness),
`endif
        .leds       (leds),
        .led_aux    (led_aux),
        .step       (step)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] bseq [8];

    initial begin
        bseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rst_n = 1'b0; enable = 1'b1; mode = 2'd0; load = 1'b0; pattern_in = 4'b0000;
        cyc(2);
        chk("rst_leds", 8'(leds), 8'b1010);
        chk("rst_step", 8'(step), 8'd0);
        chk("rst_aux", 8'(led_aux), 8'd1);

        // ROTL: first step on the 4th edge after release
        rst_n = 1'b1;
        cyc(3);
        chk("rotl_pre_leds", 8'(leds), 8'b1010);
        chk("rotl_pre_step", 8'(step), 8'd0);
        cyc(1);
        chk("rotl1_leds", 8'(leds), 8'b0101);
        chk("rotl1_step", 8'(step), 8'd1);
        cyc(1);
        chk("rotl1_step_drop", 8'(step), 8'd0);
        cyc(2);
        chk("rotl_gap_leds", 8'(leds), 8'b0101);
        chk("rotl_gap_step", 8'(step), 8'd0);
        cyc(1);
        chk("rotl2_leds", 8'(leds), 8'b1010);
        chk("rotl2_step", 8'(step), 8'd1);

        // SWAP_PAIRS
        mode = 2'd3;
        cyc(4);
        chk("swap1_leds", 8'(leds), 8'b0101);
        chk("swap1_step", 8'(step), 8'd1);
        cyc(4);
        chk("swap2_leds", 8'(leds), 8'b1010);
        cyc(4);
        chk("swap3_leds", 8'(leds), 8'b0101);
        chk("swap_aux", 8'(led_aux), 8'd1);

        // BOUNCE walker from a non-one-hot pattern
        mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            cyc(4);
            chk($sformatf("bounce%0d_leds", i), 8'(leds), 8'(bseq[i]));
            chk($sformatf("bounce%0d_step", i), 8'(step), 8'd1);
        end

        // Pause at div=2 for 10 cycles
        cyc(2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk($sformatf("pause%0d_step", i), 8'(step), 8'd0);
        end
        chk("pause_leds", 8'(leds), 8'b0010);
        enable = 1'b1;
        cyc(1);
        chk("resume1_step", 8'(step), 8'd0);
        cyc(1);
        chk("resume2_leds", 8'(leds), 8'b0100);
        chk("resume2_step", 8'(step), 8'd1);

        // Load on a step cycle suppresses the step
        mode = 2'd0;
        cyc(3);
        load = 1'b1; pattern_in = 4'b0011;
        cyc(1);
        load = 1'b0;
        chk("load_leds", 8'(leds), 8'b0011);
        chk("load_step", 8'(step), 8'd0);
        cyc(3);
        chk("load_hold_leds", 8'(leds), 8'b0011);
        chk("load_hold_step", 8'(step), 8'd0);
        cyc(1);
        chk("load_rotl_leds", 8'(leds), 8'b0110);
        chk("load_rotl_step", 8'(step), 8'd1);

        // All-ones invariant under ROTR
        mode = 2'd1;
        load = 1'b1; pattern_in = 4'b1111;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("ones_leds", 8'(leds), 8'b1111);
        chk("ones_step", 8'(step), 8'd1);

        // Reset mid-BOUNCE
        mode = 2'd2;
        cyc(4);
        chk("bounce_entry_leds", 8'(leds), 8'b0001);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_leds", 8'(leds), 8'b1010);
        chk("midrst_step", 8'(step), 8'd0);
        cyc(1);
        mode = 2'd0;
        rst_n = 1'b1;
        cyc(3);
        chk("postrst_pre_leds", 8'(leds), 8'b1010);
        cyc(1);
        chk("postrst_leds", 8'(leds), 8'b0101);
        chk("postrst_step", 8'(step), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer for small FPGA boards: a free-running divider produces a step strobe, and each step advances an NUM_LEDS-wide pattern register according to a selectable mode.
Generalises the fixed 4-LED pair-swap spinner to any LED count, exact step period, four motion modes, runtime pattern load and pause.
Sits directly at board top level between the board oscillator and the LED pins.

Parameters:
NUM_LEDS, 4, pattern width; must be even and >=2
STEP_DIV, 6000000, clk cycles per step; must be >=2
DIV_W, 24, divider width; must satisfy 2**DIV_W > STEP_DIV-1
INIT_PATTERN, 4'b1010 (replicated "10" to NUM_LEDS), pattern loaded at reset
PWM_BITS, 4, brightness resolution (optional feature only)

Ports:
clk  in  1  board clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run divider and stepping; 0 = freeze divider and pattern
mode  in  2  0 ROTL, 1 ROTR, 2 BOUNCE, 3 SWAP_PAIRS
load  in  1  single-cycle strobe: load pattern_in
pattern_in  in  NUM_LEDS  pattern to load
leds  out  NUM_LEDS  LED drive; bit i drives LED i+1
led_aux  out  1  constant 1 (power indicator)
step  out  1  registered 1-cycle pulse coincident with each pattern update

Behaviour:
- Reset (async assert, sync release): div=0, pattern=INIT_PATTERN, state=RUN, bounce_dir=up, step=0, leds=INIT_PATTERN, led_aux=1.
- Divider: when enable=1, div counts 0..STEP_DIV-1, then wraps to 0. The wrap cycle is the step cycle, so the step period is exactly STEP_DIV clocks.
- Step cycle: pattern updates on the same edge and step=1 in the following cycle, together with the new leds value.
- Latency: the first step occurs STEP_DIV cycles after reset release, with enable held high.
- FSM states:
  - RUN: enable=1; counting and stepping.
  - PAUSE: enable=0; div and pattern held.
  - Transitions: RUN->PAUSE on enable=0; PAUSE->RUN on enable=1, resuming from the held div value with no restart.
- Modes, applied at each step:
  - ROTL: p <= {p[N-2:0], p[N-1]}.
  - ROTR: p <= {p[0], p[N-1:1]}.
  - SWAP_PAIRS: for every even i, p[i] <-> p[i+1].
  - BOUNCE: single-hot walker. Shift toward MSB while dir=up; when the current bit is MSB, reverse dir and shift toward LSB; mirror behaviour at LSB. The end bit is shown for exactly one step and never repeats.
- Mode change:
  - The mode is sampled every cycle; a change takes effect at the next step.
  - Entering BOUNCE, or any BOUNCE step where pattern is not one-hot, forces p=1 (bit0) with dir=up instead of shifting.
- Load:
  - load=1 sets pattern=pattern_in and div=0 on the next edge, with no step pulse.
  - Load has priority over a coincident step.
  - Load is honoured in PAUSE as well.
- All-zero or all-one patterns are legal in ROTL/ROTR/SWAP_PAIRS and stay invariant.
- NUM_LEDS=2: ROTL, ROTR and SWAP_PAIRS are identical; BOUNCE alternates 01/10.
- Reset asserted mid-operation returns the block to reset values immediately, regardless of state.

Optional Feature:
LED_SEQ_PWM_EN.
- Defined:
  - Adds input brightness[PWM_BITS-1:0] and a free-running PWM_BITS counter pwm_cnt, reset to 0.
  - leds = pattern & {NUM_LEDS{pwm_cnt < brightness}}, registered.
  - brightness=0 gives LEDs dark; the maximum value gives a duty of (2**PWM_BITS-1)/2**PWM_BITS.
- Undefined: the port and counter are absent; leds = pattern exactly.

Decomposition:
- Package led_seq_pkg: mode enum (MODE_ROTL, MODE_ROTR, MODE_BOUNCE, MODE_SWAP), FSM state enum (ST_RUN, ST_PAUSE), and a function computing the next pattern from (pattern, mode, dir).
- One sub-module: led_step_div (parametrised STEP_DIV/DIV_W counter with enable, clear and a wrap strobe), reusable by other board demos.

Test Plan (STEP_DIV=4, NUM_LEDS=4):
- Reset release, enable=1, mode=ROTL -> leds 1010 until the 4th edge, then 0101 with step=1 for one cycle; the next update occurs 4 cycles later.
- mode=SWAP_PAIRS from 1010 -> 0101, 1010, 0101 on successive steps; led_aux=1 throughout.
- mode=BOUNCE from 1010 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- enable=0 for 10 cycles at div=2 -> leds and step frozen; after re-enable the next step occurs 2 cycles later.
- load=1 with pattern_in=0011 on a step cycle -> leds=0011, no step pulse, next step 4 cycles later gives 0110 (ROTL).
- rst_n pulsed low mid-BOUNCE -> leds=1010 immediately, step=0, div restarts; with LED_SEQ_PWM_EN and brightness=8 (PWM_BITS=4), lit LEDs are high for 8 of every 16 cycles.
